// File: rtl/regfile_scoreboard.sv
// Two-read / two-write register file with write-port bypass and a per-register
// pending-write scoreboard that blocks hazardous issues.
module regfile_scoreboard #(
  parameter  int DATA_W   = 32,
  parameter  int ADDR_W   = 5,
  parameter  int ZERO_REG = 1,
  localparam int NREGS    = 1 << ADDR_W,
  localparam int CNT_W    = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic [DATA_W-1:0] Read_Data,
  output logic [DATA_W-1:0] Read_Data2,
  input  logic              wa_en,
  input  logic [ADDR_W-1:0] wa_addr,
  input  logic [DATA_W-1:0] wa_data,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_rd,
  output logic              stall,
  output logic [NREGS-1:0]  busy_vec,
  output logic [CNT_W-1:0]  pend_cnt,
  output logic              err_collide
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  busy_q, busy_d;
  logic [NREGS-1:0]  wa_hit, wb_hit, wr_mask, set_mask, busy_eff;
  logic [CNT_W-1:0]  pend_cnt_q, pend_cnt_d;
  logic              err_q, err_d;
  logic              accept;

  // Port B takes priority over port A; a hardwired zero register hides all bypass.
  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] arr_val,
    input logic              a_en,
    input logic [ADDR_W-1:0] a_addr,
    input logic [DATA_W-1:0] a_data,
    input logic              b_en,
    input logic [ADDR_W-1:0] b_addr,
    input logic [DATA_W-1:0] b_data
  );
    if (ZERO_REG != 0 && addr == '0) return '0;
    if (b_en && b_addr == addr)      return b_data;
    if (a_en && a_addr == addr)      return a_data;
    return arr_val;
  endfunction

  assign Read_Data  = read_port(rs, regs_q[rs], wa_en, wa_addr, wa_data,
                                wb_en, wb_addr, wb_data);
  assign Read_Data2 = read_port(rt, regs_q[rt], wa_en, wa_addr, wa_data,
                                wb_en, wb_addr, wb_data);

  // Per-register write decode; writes to a hardwired zero register vanish here,
  // so they can neither collide nor touch the scoreboard.
  always_comb begin
    // NOTE: every combinational output gets a default before any conditional
    // update so no path leaves a value held, which would infer a latch.
    wa_hit = '0;
    wb_hit = '0;
    for (int i = 0; i < NREGS; i++) begin
      wa_hit[i] = wa_en && (wa_addr == ADDR_W'(i));
      wb_hit[i] = wb_en && (wb_addr == ADDR_W'(i));
    end
    if (ZERO_REG != 0) begin
      wa_hit[0] = 1'b0;
      wb_hit[0] = 1'b0;
    end
  end

  assign wr_mask = wa_hit | wb_hit;
  assign err_d   = |(wa_hit & wb_hit);

  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
      if (wb_hit[i])      regs_d[i] = wb_data;
      else if (wa_hit[i]) regs_d[i] = wa_data;
    end
  end

  // A write landing this cycle releases its register early, so a dependent
  // issue in the same cycle is not held back.
  always_comb begin
    busy_eff = busy_q & ~wr_mask;
    if (ZERO_REG != 0) busy_eff[0] = 1'b0;
  end

  assign stall  = iss_en & (busy_eff[rs] | busy_eff[rt] | busy_eff[iss_rd]);
  assign accept = iss_en & ~stall;

  always_comb begin
    set_mask = '0;
    if (accept) set_mask[iss_rd] = 1'b1;
    if (ZERO_REG != 0) set_mask[0] = 1'b0;
  end

  // Set is applied after clear so a same-cycle issue keeps its register busy.
  assign busy_d = (busy_q & ~wr_mask) | set_mask;

  always_comb begin
    pend_cnt_d = '0;
    for (int i = 0; i < NREGS; i++) begin
      pend_cnt_d = pend_cnt_d + CNT_W'(busy_d[i]);
    end
  end

  // NOTE: the register array sits in plain flops with async reset because the
  // whole file must read zero the instant rst rises; a RAM macro could not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      busy_q     <= '0;
      pend_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
      busy_q     <= busy_d;
      pend_cnt_q <= pend_cnt_d;
      err_q      <= err_d;
    end
  end

  assign busy_vec    = busy_q;
  assign pend_cnt    = pend_cnt_q;
  assign err_collide = err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomized and directed bench for regfile_scoreboard against an array/bit-vector
// reference model of the register file and its pending-write scoreboard.
module tb_regfile_scoreboard;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 32;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] rs, rt;
  logic [DATA_W-1:0] Read_Data, Read_Data2;
  logic              wa_en, wb_en, iss_en;
  logic [ADDR_W-1:0] wa_addr, wb_addr, iss_rd;
  logic [DATA_W-1:0] wa_data, wb_data;
  logic              stall;
  logic [NREGS-1:0]  busy_vec;
  logic [ADDR_W:0]   pend_cnt;
  logic              err_collide;

  regfile_scoreboard #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .rs(rs), .rt(rt),
    .Read_Data(Read_Data), .Read_Data2(Read_Data2),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .iss_en(iss_en), .iss_rd(iss_rd), .stall(stall),
    .busy_vec(busy_vec), .pend_cnt(pend_cnt), .err_collide(err_collide)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: register contents, pending-write set, expected error pulse.
  logic [DATA_W-1:0] m_regs [NREGS];
  logic [NREGS-1:0]  m_busy;
  logic              m_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
    m_busy = '0;
    m_err  = 1'b0;
  endtask

  function automatic logic [DATA_W-1:0] m_read(input logic [ADDR_W-1:0] a);
    if (a == 0) return '0;
    if (wb_en && wb_addr == a) return wb_data;
    if (wa_en && wa_addr == a) return wa_data;
    return m_regs[a];
  endfunction

  function automatic bit m_blocked(input logic [ADDR_W-1:0] a);
    bit written;
    written = (wa_en && wa_addr == a) || (wb_en && wb_addr == a);
    return (a != 0) && m_busy[a] && !written;
  endfunction

  task automatic idle();
    wa_en = 0; wa_addr = '0; wa_data = '0;
    wb_en = 0; wb_addr = '0; wb_data = '0;
    iss_en = 0; iss_rd = '0; rs = '0; rt = '0;
  endtask

  // Called just after a rising edge with inputs set; checks the combinational
  // outputs mid-cycle, then the registered outputs just after the next edge.
  task automatic cycle();
    bit exp_stall, accept, coll;
    #2;
    check("rd1", 64'(Read_Data), 64'(m_read(rs)));
    check("rd2", 64'(Read_Data2), 64'(m_read(rt)));
    exp_stall = iss_en && (m_blocked(rs) || m_blocked(rt) || m_blocked(iss_rd));
    check("stall", 64'(stall), 64'(exp_stall));
    accept = iss_en && !exp_stall;
    coll   = wa_en && wb_en && (wa_addr == wb_addr) && (wa_addr != 0);
    if (wa_en && wa_addr != 0) begin m_regs[wa_addr] = wa_data; m_busy[wa_addr] = 1'b0; end
    if (wb_en && wb_addr != 0) begin m_regs[wb_addr] = wb_data; m_busy[wb_addr] = 1'b0; end
    if (accept && iss_rd != 0) m_busy[iss_rd] = 1'b1;
    m_err = coll;
    @(posedge clk);
    #1;
    check("busy_vec", 64'(busy_vec), 64'(m_busy));
    check("pend_cnt", 64'(pend_cnt), 64'($countones(m_busy)));
    check("err_collide", 64'(err_collide), 64'(m_err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    rst = 1'b0;
    model_clear();
    #1 rst = 1'b1;
    #2;
    check("rst_busy", 64'(busy_vec), 64'(0));
    check("rst_pend", 64'(pend_cnt), 64'(0));
    check("rst_err", 64'(err_collide), 64'(0));
    check("rst_rd", 64'(Read_Data), 64'(0));
    #9 rst = 1'b0;
    @(posedge clk);
    #1;

    // Bypass then array read of reg 5.
    idle(); wa_en = 1; wa_addr = 5; wa_data = 32'h1234; rs = 5; cycle();
    check("bypass_hold", 64'(m_regs[5]), 64'(32'h1234));
    idle(); rs = 5; cycle();

    // Collision on reg 7: port B wins, error pulse lasts one cycle.
    idle(); wa_en = 1; wb_en = 1; wa_addr = 7; wb_addr = 7;
    wa_data = 32'hAAAA; wb_data = 32'hBBBB; rs = 7; cycle();
    idle(); rs = 7; cycle();

    // Hazard on reg 3, released by a same-cycle port A write.
    idle(); iss_en = 1; iss_rd = 3; cycle();
    idle(); iss_en = 1; iss_rd = 10; rs = 3; cycle();
    idle(); iss_en = 1; iss_rd = 10; rs = 3; wa_en = 1; wa_addr = 3; wa_data = 32'h33; cycle();

    // Set wins over a same-cycle port B write to reg 4.
    idle(); iss_en = 1; iss_rd = 4; cycle();
    idle(); iss_en = 1; iss_rd = 4; wb_en = 1; wb_addr = 4; wb_data = 32'h44; cycle();

    // Zero register ignores writes and issues.
    idle(); wa_en = 1; wa_addr = 0; wa_data = 32'hFFFF; iss_en = 1; iss_rd = 0; cycle();
    idle(); wa_en = 1; wb_en = 1; wa_addr = 0; wb_addr = 0; wb_data = 32'h5; cycle();

    // Randomized traffic; odd passes use a narrow address range to provoke hazards.
    for (int n = 0; n < 400; n++) begin
      int lim;
      lim = (n % 2 == 1) ? 7 : 31;
      wa_en   = 1'($urandom_range(0, 1));
      wa_addr = 5'($urandom_range(0, lim));
      wa_data = $urandom;
      wb_en   = ($urandom_range(0, 3) == 0);
      wb_addr = ($urandom_range(0, 4) == 0) ? wa_addr : 5'($urandom_range(0, lim));
      wb_data = $urandom;
      iss_en  = 1'($urandom_range(0, 1));
      iss_rd  = 5'($urandom_range(0, lim));
      rs      = 5'($urandom_range(0, lim));
      rt      = 5'($urandom_range(0, lim));
      cycle();
    end

    // Fill the file, mark ten registers busy, then reset between edges.
    for (int a = 1; a < NREGS; a++) begin
      idle(); wa_en = 1; wa_addr = 5'(a); wa_data = $urandom | 32'h1; rs = 5'(a); cycle();
    end
    for (int a = 1; a <= 10; a++) begin
      idle(); iss_en = 1; iss_rd = 5'(a); cycle();
    end
    check("pend_ten", 64'(pend_cnt), 64'(10));
    #2;
    idle();
    rst = 1'b1;
    #1;
    check("arst_busy", 64'(busy_vec), 64'(0));
    check("arst_pend", 64'(pend_cnt), 64'(0));
    check("arst_err", 64'(err_collide), 64'(0));
    for (int a = 0; a < NREGS; a += 3) begin
      rs = 5'(a); rt = 5'(NREGS - 1 - a);
      #0.1;
      check("arst_rd1", 64'(Read_Data), 64'(0));
      check("arst_rd2", 64'(Read_Data2), 64'(0));
    end
    wa_en = 1; wa_addr = 9; wa_data = 32'hCAFE;
    wb_en = 1; wb_addr = 12; wb_data = 32'hBEEF;
    rs = 9; rt = 12;
    #0.5;
    check("rst_byp_a", 64'(Read_Data), 64'(32'hCAFE));
    check("rst_byp_b", 64'(Read_Data2), 64'(32'hBEEF));
    @(posedge clk);
    #1;
    idle();
    rst = 1'b0;
    model_clear();
    rs = 9; rt = 12;
    #1;
    check("rst_drop_a", 64'(Read_Data), 64'(0));
    check("rst_drop_b", 64'(Read_Data2), 64'(0));
    @(posedge clk);
    #1;

    // Normal operation resumes after reset.
    idle(); iss_en = 1; iss_rd = 6; wa_en = 1; wa_addr = 2; wa_data = 32'h77; cycle();
    for (int n = 0; n < 30; n++) begin
      wa_en   = 1'($urandom_range(0, 1));
      wa_addr = 5'($urandom_range(0, 7));
      wa_data = $urandom;
      wb_en   = 1'($urandom_range(0, 1));
      wb_addr = 5'($urandom_range(0, 7));
      wb_data = $urandom;
      iss_en  = 1'($urandom_range(0, 1));
      iss_rd  = 5'($urandom_range(0, 7));
      rs      = 5'($urandom_range(0, 7));
      rt      = 5'($urandom_range(0, 7));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
